osnt_tx_queue: RTL and testbench

Single-clock store-and-forward TX queue between the OSNT packet generator and the 100G MAC TX AXI-Stream. Releases a packet to the MAC only once it is fully buffered, so tvalid stays continuous mid-frame. Captures a TX timestamp from the shared stamp_counter on each packet's first output beat. Reports sent, oversize and underrun events for the statistics block.

---
 rtl/osnt_tx_pkg.sv | 21 ++
 rtl/osnt_tx_queue_if.sv | 21 ++
 rtl/osnt_sync_fifo.sv | 58 +++++
 rtl/osnt_tx_queue.sv | 176 +++++++++++++++++
 tb/tb_osnt_tx_queue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osnt_tx_pkg.sv
`default_nettype none
// =============================================================================
// Module   : osnt_tx_pkg
// Brief    : Shared constants, state encodings and helpers for the OSNT TX queue.
// Revision : 1.0 - initial release
// =============================================================================
package osnt_tx_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_CUT  = 2'd2;

    localparam int unsigned c_STAMP_W = 64;

    // FIFO word layout is {tlast, tkeep, tdata, tuser}
    function automatic int fifo_word_width(input int data_w, input int user_w);
        return user_w + data_w + data_w / 8 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osnt_tx_queue_if.sv
`default_nettype none
// =============================================================================
// Module   : osnt_tx_queue_if
// Brief    : AXI-Stream bundle with master/slave views for the OSNT TX queue.
// Revision : 1.0 - initial release
// =============================================================================
interface osnt_tx_queue_if #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_USER_WIDTH = 128
);
    logic [AXI_DATA_WIDTH-1:0]   tdata;
    logic [AXI_DATA_WIDTH/8-1:0] tkeep;
    logic [AXI_USER_WIDTH-1:0]   tuser;
    logic                        tvalid;
    logic                        tlast;
    logic                        tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/osnt_sync_fifo.sv
`default_nettype none
// =============================================================================
// Module   : osnt_sync_fifo
// Brief    : First-word-fall-through synchronous FIFO with full/empty flags.
// Revision : 1.0 - initial release
// =============================================================================
module osnt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;

    // Extra pointer bit distinguishes full from empty when addresses match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    always_ff @(posedge clk) begin
        if (i_wr_en && !w_full) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en && !w_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en && !w_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/osnt_tx_queue.sv
`default_nettype none
// =============================================================================
// Module   : osnt_tx_queue
// Brief    : Store-and-forward TX queue to the MAC with TX timestamp capture and
//            statistics pulses. Macro OSNT_TX_STAMP_INSERT_EN overwrites
//            o_tdata[63:0] with stamp_counter on each packet's first beat.
// Revision : 1.0 - initial release
// =============================================================================
module osnt_tx_queue
    import osnt_tx_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_USER_WIDTH = 128,
    parameter int TXQUEUE_DEPTH  = 128,
    parameter int PKT_CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    osnt_tx_queue_if.slave           i_axis,
    osnt_tx_queue_if.master          o_axis,
    input  logic [c_STAMP_W-1:0]     stamp_counter,
    output logic [c_STAMP_W-1:0]     tx_stamp,
    output logic                     tx_stamp_valid,
    output logic                     tx_pkt_sent,
    output logic                     tx_oversize,
    output logic                     tx_underrun,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);
    localparam int c_KEEP_W = AXI_DATA_WIDTH / 8;
    localparam int c_WORD_W = fifo_word_width(AXI_DATA_WIDTH, AXI_USER_WIDTH);

    logic [1:0]                r_state;
    logic [PKT_CNT_WIDTH-1:0]  r_pkt_cnt;
    logic                      r_cut_started;
    logic [c_STAMP_W-1:0]      r_tx_stamp;
    logic                      r_stamp_valid;
    logic                      r_pkt_sent;
    logic                      r_oversize;
    logic                      r_underrun;

    logic [c_WORD_W-1:0]       w_q_word;
    logic                      w_q_last;
    logic [c_KEEP_W-1:0]       w_q_keep;
    logic [AXI_DATA_WIDTH-1:0] w_q_data;
    logic [AXI_USER_WIDTH-1:0] w_q_user;
    logic [AXI_DATA_WIDTH-1:0] w_out_data;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_in_hs;
    logic                      w_out_valid;
    logic                      w_out_hs;
    logic                      w_first_beat;
    logic                      w_first_hs;
    logic                      w_in_last_hs;
    logic                      w_out_last_hs;

    assign w_in_hs       = i_axis.tvalid && !w_full;
    assign i_axis.tready = !w_full;

    osnt_sync_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (TXQUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_in_hs),
        .i_wr_data ({i_axis.tlast, i_axis.tkeep, i_axis.tdata, i_axis.tuser}),
        .i_rd_en   (w_out_hs),
        .o_rd_data (w_q_word),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign {w_q_last, w_q_keep, w_q_data, w_q_user} = w_q_word;

    always_comb begin
        w_out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: w_out_valid = (r_pkt_cnt != '0);
            c_ST_SEND: w_out_valid = !w_empty;
            c_ST_CUT:  w_out_valid = !w_empty;
            default:   w_out_valid = 1'b0;
        endcase
    end

    assign w_out_hs      = w_out_valid && o_axis.tready;
    assign w_in_last_hs  = w_in_hs && i_axis.tlast;
    assign w_out_last_hs = w_out_hs && w_q_last;
    // Every beat offered in IDLE opens a packet; in CUT only the first one does
    assign w_first_beat  = (r_state == c_ST_IDLE) || ((r_state == c_ST_CUT) && !r_cut_started);
    assign w_first_hs    = w_out_hs && w_first_beat;

`ifdef OSNT_TX_STAMP_INSERT_EN
    always_comb begin
        w_out_data = w_q_data;
        if (w_first_beat) begin
            w_out_data[c_STAMP_W-1:0] = stamp_counter;
        end
    end
`else
    assign w_out_data = w_q_data;
`endif

    // Payload is masked while idle so stale RAM contents never reach the MAC
    assign o_axis.tvalid = w_out_valid;
    assign o_axis.tlast  = w_out_valid && w_q_last;
    assign o_axis.tkeep  = w_out_valid ? w_q_keep   : '0;
    assign o_axis.tdata  = w_out_valid ? w_out_data : '0;
    assign o_axis.tuser  = w_out_valid ? w_q_user   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_pkt_cnt     <= '0;
            r_cut_started <= 1'b0;
            r_tx_stamp    <= '0;
            r_stamp_valid <= 1'b0;
            r_pkt_sent    <= 1'b0;
            r_oversize    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_stamp_valid <= w_first_hs;
            r_pkt_sent    <= w_out_last_hs;
            r_oversize    <= 1'b0;
            r_underrun    <= (r_state == c_ST_CUT) && w_empty && o_axis.tready;

            if (w_first_hs) begin
                r_tx_stamp <= stamp_counter;
            end

            if (w_in_last_hs && !w_out_last_hs && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + PKT_CNT_WIDTH'(1);
            end else if (!w_in_last_hs && w_out_last_hs && (r_pkt_cnt != '0)) begin
                r_pkt_cnt <= r_pkt_cnt - PKT_CNT_WIDTH'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_out_hs) begin
                        if (!w_q_last) begin
                            r_state <= c_ST_SEND;
                        end
                    end else if (w_full && (r_pkt_cnt == '0)) begin
                        r_state       <= c_ST_CUT;
                        r_oversize    <= 1'b1;
                        r_cut_started <= 1'b0;
                    end
                end
                c_ST_SEND: begin
                    if (w_out_last_hs) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_CUT: begin
                    if (w_out_hs) begin
                        r_cut_started <= 1'b1;
                    end
                    if (w_out_last_hs) begin
                        r_state       <= c_ST_IDLE;
                        r_cut_started <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign tx_stamp       = r_tx_stamp;
    assign tx_stamp_valid = r_stamp_valid;
    assign tx_pkt_sent    = r_pkt_sent;
    assign tx_oversize    = r_oversize;
    assign tx_underrun    = r_underrun;
    assign pkt_cnt        = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_osnt_tx_queue.sv
`default_nettype none
// =============================================================================
// Module   : tb_osnt_tx_queue
// Brief    : Self-checking bench for osnt_tx_queue: vector table, directed corner
//            sequences and random traffic against a packet-queue reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_osnt_tx_queue;
    localparam int c_DW    = 128;
    localparam int c_UW    = 16;
    localparam int c_KW    = c_DW / 8;
    localparam int c_DEPTH = 8;
    localparam int c_PCW   = 4;

    typedef struct packed {
        logic            last;
        logic [c_KW-1:0] keep;
        logic [c_DW-1:0] data;
        logic [c_UW-1:0] user;
    } beat_t;

    typedef struct {
        bit iv, il, ordy;
        bit e_v, e_l, e_sent, e_sv;
        int e_cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [63:0]      stamp_counter = 64'd0;
    logic [63:0]      tx_stamp;
    logic             tx_stamp_valid;
    logic             tx_pkt_sent;
    logic             tx_oversize;
    logic             tx_underrun;
    logic [c_PCW-1:0] pkt_cnt;

    osnt_tx_queue_if #(.AXI_DATA_WIDTH(c_DW), .AXI_USER_WIDTH(c_UW)) in_if ();
    osnt_tx_queue_if #(.AXI_DATA_WIDTH(c_DW), .AXI_USER_WIDTH(c_UW)) out_if ();

    osnt_tx_queue #(
        .AXI_DATA_WIDTH (c_DW),
        .AXI_USER_WIDTH (c_UW),
        .TXQUEUE_DEPTH  (c_DEPTH),
        .PKT_CNT_WIDTH  (c_PCW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_axis         (in_if),
        .o_axis         (out_if),
        .stamp_counter  (stamp_counter),
        .tx_stamp       (tx_stamp),
        .tx_stamp_valid (tx_stamp_valid),
        .tx_pkt_sent    (tx_pkt_sent),
        .tx_oversize    (tx_oversize),
        .tx_underrun    (tx_underrun),
        .pkt_cnt        (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_sent  = 0;
    int n_ovs   = 0;
    int n_und   = 0;
    int rdy_mode = 0;
    bit force_stamp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is the ordered stream of accepted beats
    beat_t       m_q[$];
    int          m_cnt;
    bit          m_mid, m_cut;
    bit          m_sent_nxt, m_sv_nxt, m_ovs_nxt, m_und_nxt;
    logic [63:0] m_stamp;
    logic [c_DW-1:0] mon_exp_data;
    bit          mon_exp_v, mon_in_hs, mon_out_hs, mon_first, mon_last;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_tvalid", out_if.tvalid, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
            chk("rst_tdata", out_if.tdata, 0);
            m_q.delete();
            m_cnt = 0; m_mid = 0; m_cut = 0; m_stamp = '0;
            m_sent_nxt = 0; m_sv_nxt = 0; m_ovs_nxt = 0; m_und_nxt = 0;
        end else begin
            if (tx_pkt_sent) n_sent++;
            if (tx_oversize) n_ovs++;
            if (tx_underrun) n_und++;
            chk("pkt_cnt", pkt_cnt, m_cnt);
            chk("i_tready", in_if.tready, m_q.size() < c_DEPTH);
            chk("tx_pkt_sent", tx_pkt_sent, m_sent_nxt);
            chk("tx_stamp_valid", tx_stamp_valid, m_sv_nxt);
            chk("tx_stamp", tx_stamp, m_stamp);
            chk("tx_oversize", tx_oversize, m_ovs_nxt);
            chk("tx_underrun", tx_underrun, m_und_nxt);
            mon_first = !m_mid;
            if (m_cut)      mon_exp_v = (m_q.size() != 0);
            else if (m_mid) mon_exp_v = 1'b1;
            else            mon_exp_v = (m_cnt != 0);
            chk("o_tvalid", out_if.tvalid, mon_exp_v);
            if (out_if.tvalid && m_q.size() > 0) begin
                mon_exp_data = m_q[0].data;
`ifdef OSNT_TX_STAMP_INSERT_EN
                if (mon_first) mon_exp_data[63:0] = stamp_counter;
`endif
                chk("o_tdata", out_if.tdata, mon_exp_data);
                chk("o_tkeep", out_if.tkeep, m_q[0].keep);
                chk("o_tuser", out_if.tuser, m_q[0].user);
                chk("o_tlast", out_if.tlast, m_q[0].last);
            end
            mon_in_hs  = in_if.tvalid && in_if.tready;
            mon_out_hs = out_if.tvalid && out_if.tready && (m_q.size() > 0);
            mon_last   = mon_out_hs && m_q[0].last;
            m_sent_nxt = mon_last;
            m_sv_nxt   = mon_out_hs && mon_first;
            if (m_sv_nxt) m_stamp = stamp_counter;
            m_und_nxt  = m_cut && (m_q.size() == 0) && out_if.tready;
            m_ovs_nxt  = 1'b0;
            if (!m_cut && !m_mid && m_cnt == 0 && m_q.size() == c_DEPTH) begin
                m_cut = 1'b1;
                m_ovs_nxt = 1'b1;
            end
            if (mon_out_hs) begin
                if (mon_last) begin
                    m_mid = 0; m_cut = 0; m_cnt--;
                end else begin
                    m_mid = 1;
                end
                void'(m_q.pop_front());
            end
            if (mon_in_hs) begin
                m_q.push_back('{last: in_if.tlast, keep: in_if.tkeep, data: in_if.tdata, user: in_if.tuser});
                if (in_if.tlast) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stamp_counter = force_stamp ? 64'h0000_0000_DEAD_BEEF : {$urandom, $urandom};
        if (rdy_mode == 1)      out_if.tready = ($urandom_range(0, 3) != 0);
        else if (rdy_mode == 2) out_if.tready = !out_if.tready;
    endtask

    task automatic rand_beat(input logic last);
        in_if.tdata = {$urandom, $urandom, $urandom, $urandom};
        in_if.tkeep = c_KW'($urandom);
        in_if.tuser = c_UW'($urandom);
        in_if.tlast = last;
    endtask

    task automatic send_beat(input logic last);
        bit done;
        int n;
        done = 0;
        n = 0;
        rand_beat(last);
        in_if.tvalid = 1'b1;
        while (!done) begin
            done = in_if.tready;
            tick();
            n++;
            if (!done && n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int b = 0; b < len; b++) send_beat(b == len - 1);
    endtask

    vec_t        tbl[21];
    logic [63:0] s_a, s_b;
    logic [63:0] d0;
    int          base, base2, len;
    bit          seen;

    initial begin
        in_if.tvalid = 1'b0; in_if.tlast = 1'b0;
        in_if.tdata = '0; in_if.tkeep = '0; in_if.tuser = '0;
        out_if.tready = 1'b1;
        for (int r = 0; r < 21; r++) tbl[r] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 1, 1};
        tbl[13] = '{0, 0, 1, 1, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 0, 0, 1, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 1, 1, 1, 0, 0, 1};
        tbl[18] = '{0, 0, 1, 1, 1, 1, 1, 1};
        tbl[19] = '{0, 0, 1, 0, 0, 1, 1, 0};

        repeat (3) tick();
        reset = 1'b0;

        // Single 3-beat packet, then two back-to-back 1-beat packets
        for (int r = 0; r < 21; r++) begin
            in_if.tvalid  = tbl[r].iv;
            out_if.tready = tbl[r].ordy;
            if (tbl[r].iv) rand_beat(tbl[r].il);
            @(negedge clk);
            chk($sformatf("tbl%0d_tvalid", r), out_if.tvalid, tbl[r].e_v);
            chk($sformatf("tbl%0d_pkt_cnt", r), pkt_cnt, tbl[r].e_cnt);
            chk($sformatf("tbl%0d_sent", r), tx_pkt_sent, tbl[r].e_sent);
            chk($sformatf("tbl%0d_stamp_valid", r), tx_stamp_valid, tbl[r].e_sv);
            chk($sformatf("tbl%0d_i_tready", r), in_if.tready, 1);
            if (tbl[r].e_v) chk($sformatf("tbl%0d_tlast", r), out_if.tlast, tbl[r].e_l);
            if (r == 18) s_a = tx_stamp;
            if (r == 19) s_b = tx_stamp;
            tick();
        end
        in_if.tvalid = 1'b0;
        chk("stamps_distinct", s_a != s_b, 1);

        // 5-beat packet drained with ready toggling every cycle
        base = n_sent;
        rdy_mode = 2;
        send_pkt(5);
        repeat (16) tick();
        rdy_mode = 0;
        out_if.tready = 1'b1;
        repeat (2) tick();
        chk("toggle_pkt_sent", n_sent - base, 1);

        // Oversize packet forces cut-through; an input stall starves it
        base = n_ovs;
        base2 = n_und;
        for (int b = 0; b < c_DEPTH; b++) send_beat(1'b0);
        repeat (14) tick();
        for (int b = 0; b < 4; b++) send_beat(b == 3);
        repeat (10) tick();
        chk("oversize_pulses", n_ovs - base, 1);
        chk("underrun_seen", (n_und - base2) > 0, 1);
        chk("cut_done_cnt", pkt_cnt, 0);
        chk("cut_done_tvalid", out_if.tvalid, 0);

        // Reset with one stalled complete packet and two partial beats buffered
        out_if.tready = 1'b0;
        send_pkt(3);
        send_beat(1'b0);
        send_beat(1'b0);
        chk("pre_rst_tvalid", out_if.tvalid, 1);
        reset = 1'b1;
        #1;
        chk("rst_now_tvalid", out_if.tvalid, 0);
        chk("rst_now_tlast", out_if.tlast, 0);
        chk("rst_now_pkt_cnt", pkt_cnt, 0);
        chk("rst_now_tx_stamp", tx_stamp, 0);
        chk("rst_now_i_tready", in_if.tready, 1);
        repeat (2) tick();
        reset = 1'b0;
        out_if.tready = 1'b1;
        base = n_sent;
        send_pkt(2);
        repeat (6) tick();
        chk("post_rst_sent", n_sent - base, 1);

        // Stamp value on first beat (inserted into tdata only with the macro)
        force_stamp = 1'b1;
        tick();
        send_beat(1'b0);
        d0 = in_if.tdata[63:0];
        send_beat(1'b1);
        seen = 0;
        for (int w = 0; w < 20 && !seen; w++) begin
            if (out_if.tvalid) seen = 1;
            else tick();
        end
        chk("stamp_wait_tvalid", seen, 1);
`ifdef OSNT_TX_STAMP_INSERT_EN
        chk("first_beat_low64", out_if.tdata[63:0], 64'h0000_0000_DEAD_BEEF);
`else
        chk("first_beat_low64", out_if.tdata[63:0], d0);
`endif
        repeat (3) tick();
        chk("tx_stamp_beef", tx_stamp, 64'h0000_0000_DEAD_BEEF);
        force_stamp = 1'b0;

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 150; p++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 12) : $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                send_beat(b == len - 1);
            end
        end
        rdy_mode = 0;
        out_if.tready = 1'b1;
        repeat (30) tick();
        chk("drain_pkt_cnt", pkt_cnt, 0);
        chk("drain_model_empty", m_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
